// File: rtl/axis_packet_arbiter.sv
// -----------------------------------------------------------------------------
// axis_packet_arbiter
//
// Shares one AXI-Stream datapath (the AES-256-CTR core's s_axis input) between
// NUM_SRC plaintext producers. Grants are round-robin and packet-atomic: once a
// source is granted it owns the output until its tlast beat has been accepted.
// Every beat is tagged with the owning source index (m_axis_tid). The first beat
// of each packet is flagged on m_axis_tuser so the core can reload key, IV and
// counter per packet.
//
// Handshake semantics (all ports): a beat transfers on a rising clk edge where
// tvalid && tready are both high. A source holds tdata/tlast stable while its
// tvalid is high and tready is low. Between beats a source may drop tvalid.
// The arbiter never gates m_axis_tvalid on m_axis_tready. The only
// ready-to-ready path is m_axis_tready -> s_axis_tready[grant].
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   s_axis_tdata    NUM_SRC*DATA_WIDTH, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tvalid   per-source valid
//   s_axis_tlast    per-source last beat of packet
//   s_axis_tready   per-source ready, at most one bit set (the granted source)
//   m_axis_tdata    muxed data to the core
//   m_axis_tvalid   muxed valid
//   m_axis_tlast    muxed last
//   m_axis_tid      index of the owning source, stable for the whole packet
//   m_axis_tuser    1 on the first beat of each packet
//   m_axis_tready   core ready
//   busy            registered FSM state: 1 while a packet is granted
// -----------------------------------------------------------------------------
module axis_packet_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_SRC    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [$clog2(NUM_SRC)-1:0]    m_axis_tid,
  output logic                          m_axis_tuser,
  input  logic                          m_axis_tready,
  output logic                          busy
);

  localparam int ID_W = $clog2(NUM_SRC);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] last_grant;
  logic            first;

  logic            pick_valid;
  logic [ID_W-1:0] pick_idx;
  int              cand;
  logic [ID_W-1:0] cand_idx;

  logic            beat;

  // ---------------------------------------------------------------------------
  // Round-robin pick: scan last_grant+1, last_grant+2, ... (mod NUM_SRC).
  // The loop walks from the farthest candidate to the nearest so the nearest
  // valid source is the last assignment and therefore wins.
  // last_grant + k never exceeds 2*NUM_SRC-1, so one subtraction wraps it.
  // ---------------------------------------------------------------------------
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_SRC) begin
        cand = cand - NUM_SRC;
      end
      cand_idx = ID_W'(cand);
      if (s_axis_tvalid[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational pass-through from the granted source. Nothing from a
  // non-granted source can reach the output because every lane is gated by the
  // grant compare, and all outputs are forced idle outside BUSY.
  // ---------------------------------------------------------------------------
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tid    = '0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = '0;
    if (state == BUSY) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant == ID_W'(i)) begin
          m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
          m_axis_tvalid    = s_axis_tvalid[i];
          m_axis_tlast     = s_axis_tlast[i];
          s_axis_tready[i] = m_axis_tready;
        end
      end
      m_axis_tid   = grant;
      m_axis_tuser = first;
    end
  end

  assign beat = m_axis_tvalid && m_axis_tready;

  // ---------------------------------------------------------------------------
  // Arbitration FSM. The IDLE cycle in which the request is seen is the one
  // bubble per packet. The first beat can move in the following cycle.
  // last_grant resets to NUM_SRC-1 so the scan starts at source 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= ID_W'(NUM_SRC - 1);
      first      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state      <= BUSY;
            grant      <= pick_idx;
            last_grant <= pick_idx;
            first      <= 1'b1;
            busy       <= 1'b1;
          end
        end
        BUSY: begin
          if (beat) begin
            first <= 1'b0;
            if (m_axis_tlast) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Only the granted source may ever see ready.
  a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(s_axis_tready));

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_packet_arbiter
//
// Bench for axis_packet_arbiter (DATA_WIDTH=128, NUM_SRC=4).
// Each source has a queue of whole packets. A packet-level reference model
// decides ownership by round-robin over requesting sources. When a packet is
// granted, the model copies that packet into the expected-beat queue
// (exp_q). Every cycle the outputs are compared against the model. Each
// scenario task also checks its own timing and ordering expectations, using
// a log of beats observed on the DUT output.
// -----------------------------------------------------------------------------
module tb_axis_packet_arbiter;

  localparam int DW = 128;
  localparam int NS = 4;
  localparam int IW = 2;
  localparam int EW = DW + IW + 2;  // {tid, tuser, tlast, tdata}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [NS*DW-1:0] s_axis_tdata;
  logic [NS-1:0]    s_axis_tvalid;
  logic [NS-1:0]    s_axis_tlast;
  logic [NS-1:0]    s_axis_tready;
  logic [DW-1:0]    m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic [IW-1:0]    m_axis_tid;
  logic             m_axis_tuser;
  logic             m_axis_tready;
  logic             busy;

  axis_packet_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tid   (m_axis_tid),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tready(m_axis_tready),
    .busy         (busy)
  );

  // ---------------- stimulus state ----------------
  logic [DW:0] src_q [NS][$];  // {last, data} per pending beat
  logic [NS-1:0] consumed;     // head beat was accepted last cycle
  logic [NS-1:0] force_low;    // keep source valid low once its beat is done
  int gap_pct  = 0;            // chance of a valid gap between beats
  int rdy_mode = 0;            // 0: ready=1, 1: random, 2: toggle
  int added_beats = 0;

  // ---------------- reference model / scoreboard ----------------
  int            m_own   = -1;       // owning source, -1 when nobody owns
  int            m_last  = NS - 1;   // most recent grant
  logic          m_first = 1'b0;
  logic [EW-1:0] exp_q[$];

  // beats seen on the DUT output
  int            obs_cyc[$];
  logic [IW-1:0] obs_tid[$];
  logic          obs_user[$];
  logic          obs_last[$];
  logic [NS-1:0] obs_rdy[$];

  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [DW:0] h;
    @(posedge clk);
    #1;
    case (rdy_mode)
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      2:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'b1;
    endcase
    for (int i = 0; i < NS; i++) begin
      if (!(s_axis_tvalid[i] && !consumed[i])) begin
        consumed[i] = 1'b0;
        if (src_q[i].size() > 0 && !force_low[i] &&
            $urandom_range(0, 99) >= gap_pct) begin
          h = src_q[i][0];
          s_axis_tvalid[i]           = 1'b1;
          s_axis_tdata[i*DW +: DW]   = h[DW-1:0];
          s_axis_tlast[i]            = h[DW];
        end else begin
          s_axis_tvalid[i]           = 1'b0;
          s_axis_tdata[i*DW +: DW]   = {$urandom, $urandom, $urandom, $urandom};
          s_axis_tlast[i]            = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  task automatic add_pkt(input int src, input int len);
    for (int b = 0; b < len; b++) begin
      logic [DW-1:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      src_q[src].push_back({(b == len - 1), d});
    end
    added_beats += len;
  endtask

  task automatic clear_obs();
    obs_cyc.delete();
    obs_tid.delete();
    obs_user.delete();
    obs_last.delete();
    obs_rdy.delete();
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NS; i++) src_q[i].delete();
    s_axis_tvalid = '0;
    consumed      = '0;
    force_low     = '0;
    added_beats   = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_stim();
    gap_pct       = 0;
    rdy_mode      = 0;
    m_axis_tready = 1'b1;
    step();
    step();
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic run_until_idle(input int max_cycles, input string name);
    int  n;
    bit  pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < max_cycles) begin
      pending = (m_own >= 0);
      for (int i = 0; i < NS; i++) if (src_q[i].size() > 0) pending = 1'b1;
      if (pending) begin
        step();
        n++;
      end
    end
    checks++;
    if (pending) begin
      errors++;
      $display("FAIL %s timeout: still pending after %0d cycles (required drained)", name, n);
    end
  endtask

  // ---------------- monitor + model ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      logic [NS+1:0] exp_ctl;
      logic [NS+1:0] got_ctl;
      logic [NS-1:0] r;
      logic [DW:0]   h;
      int            idx;

      if (m_axis_tvalid && m_axis_tready) begin
        obs_cyc.push_back(cyc);
        obs_tid.push_back(m_axis_tid);
        obs_user.push_back(m_axis_tuser);
        obs_last.push_back(m_axis_tlast);
        obs_rdy.push_back(s_axis_tready);
      end

      r = '0;
      if (m_own < 0) begin
        exp_ctl = '0;
      end else begin
        r[m_own] = m_axis_tready;
        exp_ctl  = {1'b1, s_axis_tvalid[m_own], r};
      end
      got_ctl = {busy, m_axis_tvalid, s_axis_tready};
      checks++;
      if (got_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL ctl @%0d: {busy,tvalid,s_tready} got=%b exp=%b", cyc, got_ctl, exp_ctl);
      end

      if (m_own >= 0) begin
        checks++;
        if ({m_axis_tid, m_axis_tuser} !== {IW'(m_own), m_first}) begin
          errors++;
          $display("FAIL tag @%0d: {tid,tuser} got=%b exp=%b", cyc,
                   {m_axis_tid, m_axis_tuser}, {IW'(m_own), m_first});
        end
        if (s_axis_tvalid[m_own]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat @%0d: output valid but expected queue empty", cyc);
          end else if ({m_axis_tid, m_axis_tuser, m_axis_tlast, m_axis_tdata} !== exp_q[0]) begin
            errors++;
            $display("FAIL beat @%0d: got=%h exp=%h", cyc,
                     {m_axis_tid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp_q[0]);
          end
        end
      end

      // next state of the model
      if (rst) begin
        m_own   = -1;
        m_last  = NS - 1;
        m_first = 1'b0;
        exp_q.delete();
      end else if (m_own < 0) begin
        idx = -1;
        for (int k = 1; k <= NS; k++) begin
          if (idx < 0 && s_axis_tvalid[(m_last + k) % NS]) idx = (m_last + k) % NS;
        end
        if (idx >= 0) begin
          m_own   = idx;
          m_last  = idx;
          m_first = 1'b1;
          for (int j = 0; j < src_q[idx].size(); j++) begin
            h = src_q[idx][j];
            exp_q.push_back({IW'(idx), (j == 0), h[DW], h[DW-1:0]});
            if (h[DW]) break;
          end
        end
      end else if (s_axis_tvalid[m_own] && m_axis_tready) begin
        h = src_q[m_own].pop_front();
        consumed[m_own] = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_first = 1'b0;
        if (h[DW]) m_own = -1;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [NS+IW+2:0] got;
    rst = 1'b1;
    clear_stim();
    step();
    step();
    #1;
    got = {busy, m_axis_tvalid, s_axis_tready, m_axis_tid, m_axis_tuser};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_state: {busy,tvalid,tready,tid,tuser} got=%b exp=0", got);
    end
    rst    = 1'b0;
    mon_en = 1'b1;
    clear_obs();
  endtask

  task automatic test_single_packet();
    int c0;
    do_reset();
    add_pkt(1, 3);
    step();
    c0 = cyc;
    run_until_idle(30, "single_packet");
    checks++;
    if (obs_cyc.size() != 3) begin
      errors++;
      $display("FAIL single_packet count: got=%0d exp=3", obs_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_cyc[k] != c0 + 1 + k || obs_tid[k] !== 2'd1 ||
            obs_user[k] !== (k == 0) || obs_last[k] !== (k == 2) ||
            obs_rdy[k] !== 4'b0010) begin
          errors++;
          $display("FAIL single_packet beat%0d: cyc=%0d tid=%0d user=%b last=%b rdy=%b exp cyc=%0d tid=1 user=%b last=%b rdy=0010",
                   k, obs_cyc[k] - c0, obs_tid[k], obs_user[k], obs_last[k], obs_rdy[k],
                   1 + k, (k == 0), (k == 2));
        end
      end
    end
  endtask

  task automatic test_all_sources();
    int c0;
    do_reset();
    for (int i = 0; i < NS; i++) add_pkt(i, 2);
    step();
    c0 = cyc;
    run_until_idle(60, "all_sources");
    checks++;
    if (obs_cyc.size() != 8) begin
      errors++;
      $display("FAIL all_sources count: got=%0d exp=8", obs_cyc.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (obs_tid[j] !== IW'(j / 2) || obs_cyc[j] != c0 + 1 + 3 * (j / 2) + (j % 2)) begin
          errors++;
          $display("FAIL all_sources beat%0d: tid=%0d cyc=%0d exp tid=%0d cyc=%0d",
                   j, obs_tid[j], obs_cyc[j] - c0, j / 2, 1 + 3 * (j / 2) + (j % 2));
        end
      end
    end
  endtask

  task automatic test_stall();
    int n;
    do_reset();
    rdy_mode      = 2;
    m_axis_tready = 1'b0;
    add_pkt(2, 4);
    step();
    step();
    add_pkt(0, 2);
    add_pkt(3, 2);
    n = 0;
    while (obs_cyc.size() < 1 && n < 20) begin
      step();
      @(negedge clk);
      #1;
      n++;
    end
    force_low[2] = 1'b1;
    repeat (3) step();
    force_low[2] = 1'b0;
    run_until_idle(100, "stall");
    checks++;
    if (obs_cyc.size() != 8) begin
      errors++;
      $display("FAIL stall count: got=%0d exp=8", obs_cyc.size());
    end else begin
      checks++;
      if ({obs_tid[0], obs_tid[1], obs_tid[2], obs_tid[3], obs_tid[4], obs_tid[6]} !==
          {2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0}) begin
        errors++;
        $display("FAIL stall order: tids=%0d%0d%0d%0d%0d%0d%0d%0d exp=22223300",
                 obs_tid[0], obs_tid[1], obs_tid[2], obs_tid[3],
                 obs_tid[4], obs_tid[5], obs_tid[6], obs_tid[7]);
      end
    end
  endtask

  task automatic test_single_beat();
    int c0;
    do_reset();
    for (int k = 0; k < 3; k++) add_pkt(3, 1);
    step();
    c0 = cyc;
    run_until_idle(30, "single_beat");
    checks++;
    if (obs_cyc.size() != 3) begin
      errors++;
      $display("FAIL single_beat count: got=%0d exp=3", obs_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_cyc[k] != c0 + 1 + 2 * k || obs_tid[k] !== 2'd3 ||
            obs_user[k] !== 1'b1 || obs_last[k] !== 1'b1) begin
          errors++;
          $display("FAIL single_beat beat%0d: cyc=%0d tid=%0d user=%b last=%b exp cyc=%0d tid=3 user=1 last=1",
                   k, obs_cyc[k] - c0, obs_tid[k], obs_user[k], obs_last[k], 1 + 2 * k);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    int n;
    do_reset();
    add_pkt(1, 4);
    n = 0;
    while (obs_cyc.size() < 1 && n < 20) begin
      step();
      @(negedge clk);
      #1;
      n++;
    end
    step();           // second beat presented
    rst = 1'b1;       // reset during the second beat
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_stim();
    #1;
    checks++;
    if ({busy, m_axis_tvalid, s_axis_tready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_packet idle: {busy,tvalid,tready} got=%b exp=000000",
               {busy, m_axis_tvalid, s_axis_tready});
    end
    clear_obs();
    add_pkt(1, 2);
    add_pkt(0, 2);
    run_until_idle(40, "reset_mid_packet");
    checks++;
    if (obs_cyc.size() != 4 || obs_tid[0] !== 2'd0 || obs_tid[2] !== 2'd1) begin
      errors++;
      $display("FAIL reset_mid_packet order: beats=%0d first tid=%0d (exp 4 beats, src0 first then src1)",
               obs_cyc.size(), (obs_cyc.size() > 0) ? int'(obs_tid[0]) : -1);
    end
  endtask

  task automatic test_fairness();
    int pkt_tid[$];
    int cnt0;
    int cnt1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      add_pkt(0, $urandom_range(1, 3));
      add_pkt(1, $urandom_range(1, 3));
    end
    run_until_idle(200, "fairness");
    for (int j = 0; j < obs_user.size(); j++) if (obs_user[j]) pkt_tid.push_back(int'(obs_tid[j]));
    cnt0 = 0;
    cnt1 = 0;
    foreach (pkt_tid[k]) begin
      if (pkt_tid[k] == 0) cnt0++;
      if (pkt_tid[k] == 1) cnt1++;
      checks++;
      if (pkt_tid[k] != k % 2) begin
        errors++;
        $display("FAIL fairness grant%0d: got src%0d exp src%0d", k, pkt_tid[k], k % 2);
      end
    end
    checks++;
    if (cnt0 != 4 || cnt1 != 4) begin
      errors++;
      $display("FAIL fairness counts: src0=%0d src1=%0d exp 4 each", cnt0, cnt1);
    end
  endtask

  task automatic test_random();
    do_reset();
    gap_pct  = 30;
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) add_pkt($urandom_range(0, NS - 1), $urandom_range(1, 4));
    run_until_idle(3000, "random");
    checks++;
    if (obs_cyc.size() != added_beats) begin
      errors++;
      $display("FAIL random beats: got=%0d exp=%0d", obs_cyc.size(), added_beats);
    end
  endtask

  initial begin
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b1;
    consumed      = '0;
    force_low     = '0;

    test_reset();
    test_single_packet();
    test_all_sources();
    test_stall();
    test_single_beat();
    test_reset_mid_packet();
    test_fairness();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
